tile_link_isolator: RTL



---
 rtl/tile_link_isolator_pkg.sv | 14 +
 rtl/tile_link_isolator_port.sv | 104 ++++++++++
 rtl/tile_link_isolator.sv | 58 +++++
 3 files changed

// File: rtl/tile_link_isolator_pkg.sv
// Shared types for the tile link isolator: per-port state encoding and counter sizing.
package tile_link_isolator_pkg;

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        FENCE    = 2'd1,
        ISOLATED = 2'd2
    } state_e;

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/tile_link_isolator_port.sv
// One port's isolation FSM: fences outgoing traffic, waits for drain and idle, then isolates.
// Purely combinational gating of valid/ready; only control state is registered.
module tile_link_isolator_port
    import tile_link_isolator_pkg::*;
#(
    parameter int   NumChannels   = 3,
    parameter int   IdleCycles    = 4,
    parameter int   TimeoutCycles = 256,
    parameter logic ResetIsolated = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   isolate_req_i,
    input  logic [NumChannels-1:0] t2n_valid_i,
    output logic [NumChannels-1:0] t2n_ready_o,
    output logic [NumChannels-1:0] t2n_valid_o,
    input  logic [NumChannels-1:0] t2n_ready_i,
    input  logic [NumChannels-1:0] n2t_valid_i,
    output logic [NumChannels-1:0] n2t_ready_o,
    output logic [NumChannels-1:0] n2t_valid_o,
    input  logic [NumChannels-1:0] n2t_ready_i,
    output logic                   isolated_o,
    output logic                   timeout_o
);

    localparam int            CntW        = cnt_width(TimeoutCycles);
    localparam logic [CntW-1:0] IdleLast    = CntW'(IdleCycles - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax      = '1;
    localparam state_e        ResetState  = ResetIsolated ? ISOLATED : ACTIVE;

    state_e                 state_q, state_d;
    logic [NumChannels-1:0] pending_q, pending_d;
    logic [CntW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [CntW-1:0]        to_cnt_q, to_cnt_d;
    logic                   timeout_q, timeout_d;

    logic [NumChannels-1:0] fwd_t2n;
    logic                   pass_n2t;
    logic                   port_idle;

    // A flit already presented to the net keeps its path open until accepted.
    assign fwd_t2n   = {NumChannels{state_q == ACTIVE}} | pending_q;
    assign pass_n2t  = (state_q != ISOLATED);
    assign port_idle = ~|pending_q & ~|n2t_valid_i;

    assign t2n_valid_o = t2n_valid_i & fwd_t2n;
    assign t2n_ready_o = t2n_ready_i & fwd_t2n;
    assign n2t_valid_o = n2t_valid_i & {NumChannels{pass_n2t}};
    assign n2t_ready_o = n2t_ready_i & {NumChannels{pass_n2t}};
    assign isolated_o  = (state_q == ISOLATED);
    assign timeout_o   = timeout_q;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        to_cnt_d   = '0;
        timeout_d  = timeout_q;
        pending_d  = t2n_valid_o & ~t2n_ready_i;
        unique case (state_q)
            ACTIVE: begin
                if (isolate_req_i) state_d = FENCE;
            end
            FENCE: begin
                if (!isolate_req_i) begin
                    state_d = ACTIVE;
                end else if (port_idle && idle_cnt_q >= IdleLast) begin
                    state_d = ISOLATED;
                end else if (to_cnt_q >= TimeoutLast) begin
                    state_d   = ISOLATED;
                    timeout_d = 1'b1;
                end else begin
                    idle_cnt_d = !port_idle ? '0 :
                                 (idle_cnt_q == CntMax) ? idle_cnt_q : idle_cnt_q + 1'b1;
                    to_cnt_d   = (to_cnt_q == CntMax) ? to_cnt_q : to_cnt_q + 1'b1;
                end
            end
            ISOLATED: begin
                if (!isolate_req_i) begin
                    state_d   = ACTIVE;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ResetState;
            pending_q  <= '0;
            idle_cnt_q <= '0;
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idle_cnt_q <= idle_cnt_d;
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: rtl/tile_link_isolator.sv
// Per-port link isolation between router ports and mesh links; data is a pure wire-through.
// Channel c of port p occupies flat index p*NumChannels+c.
module tile_link_isolator
    import tile_link_isolator_pkg::*;
#(
    parameter int   NumPorts      = 4,
    parameter int   NumChannels   = 3,
    parameter int   FlitWidth     = 64,
    parameter int   IdleCycles    = 4,
    parameter int   TimeoutCycles = 256,
    parameter logic ResetIsolated = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NumPorts-1:0]                      isolate_req_i,
    output logic [NumPorts-1:0]                      isolated_o,
    output logic [NumPorts-1:0]                      timeout_o,
    input  logic [NumPorts*NumChannels-1:0]          t2n_valid_i,
    output logic [NumPorts*NumChannels-1:0]          t2n_ready_o,
    input  logic [NumPorts*NumChannels*FlitWidth-1:0] t2n_data_i,
    output logic [NumPorts*NumChannels-1:0]          t2n_valid_o,
    input  logic [NumPorts*NumChannels-1:0]          t2n_ready_i,
    output logic [NumPorts*NumChannels*FlitWidth-1:0] t2n_data_o,
    input  logic [NumPorts*NumChannels-1:0]          n2t_valid_i,
    output logic [NumPorts*NumChannels-1:0]          n2t_ready_o,
    input  logic [NumPorts*NumChannels*FlitWidth-1:0] n2t_data_i,
    output logic [NumPorts*NumChannels-1:0]          n2t_valid_o,
    input  logic [NumPorts*NumChannels-1:0]          n2t_ready_i,
    output logic [NumPorts*NumChannels*FlitWidth-1:0] n2t_data_o
);

    assign t2n_data_o = t2n_data_i;
    assign n2t_data_o = n2t_data_i;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        tile_link_isolator_port #(
            .NumChannels  (NumChannels),
            .IdleCycles   (IdleCycles),
            .TimeoutCycles(TimeoutCycles),
            .ResetIsolated(ResetIsolated)
        ) u_port (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .isolate_req_i(isolate_req_i[p]),
            .t2n_valid_i  (t2n_valid_i[p*NumChannels +: NumChannels]),
            .t2n_ready_o  (t2n_ready_o[p*NumChannels +: NumChannels]),
            .t2n_valid_o  (t2n_valid_o[p*NumChannels +: NumChannels]),
            .t2n_ready_i  (t2n_ready_i[p*NumChannels +: NumChannels]),
            .n2t_valid_i  (n2t_valid_i[p*NumChannels +: NumChannels]),
            .n2t_ready_o  (n2t_ready_o[p*NumChannels +: NumChannels]),
            .n2t_valid_o  (n2t_valid_o[p*NumChannels +: NumChannels]),
            .n2t_ready_i  (n2t_ready_i[p*NumChannels +: NumChannels]),
            .isolated_o   (isolated_o[p]),
            .timeout_o    (timeout_o[p])
        );
    end

endmodule
